// File: rtl/mem_stage_access.sv
// mem_stage_access: MEM pipeline stage driving a req/ack data-memory port and the MEM/WB register.
module mem_stage_access #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] MEM_Instr,
  input  logic [31:0] MEM_PC,
  input  logic        MEM_RegWrite,
  input  logic        MEM_MemToReg,
  input  logic        MEM_MemWrite,
  input  logic [4:0]  MEM_WriteReg,
  input  logic [31:0] MEM_WriteData,
  input  logic [31:0] MEM_AluResult,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        mem_err,
  output logic [31:0] WB_Instr,
  output logic [31:0] WB_PC,
  output logic        WB_RegWrite,
  output logic        WB_MemToReg,
  output logic [4:0]  WB_WriteReg,
  output logic [31:0] WB_ReadData,
  output logic [31:0] WB_AluResult
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic access, misaligned, issue, timeout_hit, wb_load, err_nx;
  always_comb begin
    access      = MEM_MemToReg | MEM_MemWrite;
    misaligned  = access & (MEM_AluResult[1:0] != 2'b00);
    issue       = (state == IDLE) & access & ~misaligned;
    timeout_hit = (state == BUSY) & ~dmem_ack & (cnt == LAST);
    wb_load     = (state == IDLE) ? ~access : dmem_ack;
    err_nx      = ((state == IDLE) & misaligned) | timeout_hit;
    mem_stall   = issue | ((state == BUSY) & ~dmem_ack & ~timeout_hit);
    state_nx    = issue ? BUSY : ((state == BUSY) & (dmem_ack | timeout_hit)) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      mem_err      <= 1'b0;
      WB_Instr     <= '0;
      WB_PC        <= '0;
      WB_RegWrite  <= 1'b0;
      WB_MemToReg  <= 1'b0;
      WB_WriteReg  <= '0;
      WB_ReadData  <= '0;
      WB_AluResult <= '0;
    end else begin
      state   <= state_nx;
      mem_err <= err_nx;
      if (issue) begin
        dmem_req   <= 1'b1;
        dmem_we    <= MEM_MemWrite;
        dmem_addr  <= MEM_AluResult;
        dmem_wdata <= MEM_WriteData;
        cnt        <= '0;
      end else if (state == BUSY) begin
        if (dmem_ack | timeout_hit) dmem_req <= 1'b0;
        else cnt <= cnt + 1'b1;
      end
      // anything that is not a plain ALU op or a completed access becomes a bubble
      if (wb_load) begin
        WB_Instr     <= MEM_Instr;
        WB_PC        <= MEM_PC;
        WB_RegWrite  <= MEM_RegWrite;
        WB_MemToReg  <= MEM_MemToReg;
        WB_WriteReg  <= MEM_WriteReg;
        WB_AluResult <= MEM_AluResult;
        if (state == BUSY) WB_ReadData <= dmem_rdata;
      end else begin
        WB_RegWrite <= 1'b0;
        WB_MemToReg <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_access.sv
// tb_mem_stage_access: randomized transaction-level check of the MEM stage against a memory model.
module tb_mem_stage_access;
  localparam int T = 4;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic [31:0] MEM_Instr = '0, MEM_PC = '0, MEM_WriteData = '0, MEM_AluResult = '0;
  logic        MEM_RegWrite = 1'b0, MEM_MemToReg = 1'b0, MEM_MemWrite = 1'b0;
  logic [4:0]  MEM_WriteReg = '0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0, mem_stall, mem_err;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic [31:0] WB_Instr, WB_PC, WB_ReadData, WB_AluResult;
  logic        WB_RegWrite, WB_MemToReg;
  logic [4:0]  WB_WriteReg;
  int checks = 0, failures = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] last_rd = '0;

  mem_stage_access #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .reset_n(reset_n), .MEM_Instr(MEM_Instr), .MEM_PC(MEM_PC),
    .MEM_RegWrite(MEM_RegWrite), .MEM_MemToReg(MEM_MemToReg), .MEM_MemWrite(MEM_MemWrite),
    .MEM_WriteReg(MEM_WriteReg), .MEM_WriteData(MEM_WriteData), .MEM_AluResult(MEM_AluResult),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .mem_err(mem_err),
    .WB_Instr(WB_Instr), .WB_PC(WB_PC), .WB_RegWrite(WB_RegWrite), .WB_MemToReg(WB_MemToReg),
    .WB_WriteReg(WB_WriteReg), .WB_ReadData(WB_ReadData), .WB_AluResult(WB_AluResult)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  task automatic chk_wb(input logic [31:0] instr, pc, alu, rd, input logic rw, m2r, input logic [4:0] wr);
    chk("wb_instr", WB_Instr, instr);
    chk("wb_pc", WB_PC, pc);
    chk("wb_rw", 32'(WB_RegWrite), 32'(rw));
    chk("wb_m2r", 32'(WB_MemToReg), 32'(m2r));
    chk("wb_reg", 32'(WB_WriteReg), 32'(wr));
    chk("wb_alu", WB_AluResult, alu);
    chk("wb_rd", WB_ReadData, rd);
  endtask

  // one instruction through MEM; delay = ack on that BUSY cycle, delay >= T means no ack
  task automatic run_op(input logic rw, m2r, mw, input logic [4:0] wr,
                        input logic [31:0] alu, wd, input int delay);
    logic [31:0] pc, instr, rd;
    int stalls;
    bit acc, mis;
    pc = $urandom; instr = $urandom;
    MEM_Instr = instr; MEM_PC = pc; MEM_RegWrite = rw; MEM_MemToReg = m2r;
    MEM_MemWrite = mw; MEM_WriteReg = wr; MEM_AluResult = alu; MEM_WriteData = wd;
    acc = m2r | mw;
    mis = acc && (alu[1:0] != 2'b00);
    dmem_ack = !acc && ($urandom_range(0, 1) == 0);
    dmem_rdata = $urandom;
    #1;
    chk("stall_idle", 32'(mem_stall), 32'(acc && !mis));
    stalls = int'(mem_stall);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    if (!acc || mis) begin
      chk("req_idle", 32'(dmem_req), 0);
      chk("err_idle", 32'(mem_err), 32'(mis));
      if (mis) begin
        chk("bubble_rw", 32'(WB_RegWrite), 0);
        chk("bubble_m2r", 32'(WB_MemToReg), 0);
      end else chk_wb(instr, pc, alu, last_rd, rw, m2r, wr);
      return;
    end
    chk("req_issue", 32'(dmem_req), 1);
    chk("we_issue", 32'(dmem_we), 32'(mw));
    chk("addr_issue", dmem_addr, alu);
    chk("wdata_issue", dmem_wdata, wd);
    chk("err_issue", 32'(mem_err), 0);
    chk("bubble_issue", 32'(WB_RegWrite), 0);
    for (int k = 0; k < T; k++) begin
      bit ack;
      ack = (k == delay);
      rd = mw ? $urandom : rd_mem(alu);
      dmem_ack = ack;
      dmem_rdata = rd;
      #1;
      chk("req_hold", 32'(dmem_req), 1);
      chk("addr_hold", dmem_addr, alu);
      chk("stall_busy", 32'(mem_stall), 32'(!ack && k != T - 1));
      stalls += int'(mem_stall);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      if (ack) begin
        chk("req_done", 32'(dmem_req), 0);
        chk("err_done", 32'(mem_err), 0);
        chk_wb(instr, pc, alu, rd, rw, m2r, wr);
        chk("stall_cnt", 32'(stalls), 32'(delay + 1));
        last_rd = rd;
        if (mw) mem[alu] = wd;
        return;
      end
      if (k == T - 1) begin
        chk("req_timeout", 32'(dmem_req), 0);
        chk("err_timeout", 32'(mem_err), 1);
        chk("bubble_timeout", 32'(WB_RegWrite), 0);
        chk("stall_cnt_to", 32'(stalls), 32'(T));
        return;
      end
      chk("bubble_busy", 32'(WB_RegWrite), 0);
      chk("err_busy", 32'(mem_err), 0);
    end
  endtask

  initial begin
    #12;
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_we", 32'(dmem_we), 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_err", 32'(mem_err), 0);
    chk("rst_stall", 32'(mem_stall), 0);
    chk_wb(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    mem[32'h100] = 32'hDEADBEEF;
    run_op(1, 0, 0, 5, 32'h1234, 0, 0);
    run_op(1, 1, 0, 7, 32'h100, 0, 3);
    run_op(0, 0, 1, 0, 32'h40, 32'hA5A5A5A5, 0);
    run_op(1, 1, 0, 3, 32'h40, 0, 1);
    run_op(1, 1, 0, 4, 32'h102, 0, 0);
    run_op(1, 1, 0, 6, 32'h100, 0, 9);
    run_op(1, 0, 0, 8, 32'h55, 0, 0);
    for (int i = 0; i < 200; i++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 2);
      a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
      case (kind)
        0: run_op(1'($urandom), 0, 0, 5'($urandom), $urandom, $urandom, 0);
        1: run_op(1, 1, 0, 5'($urandom), a, $urandom, $urandom_range(0, 5));
        default: run_op(0, 0, 1, 5'($urandom), a, $urandom, $urandom_range(0, 5));
      endcase
    end
    MEM_MemToReg = 1'b1; MEM_MemWrite = 1'b0; MEM_RegWrite = 1'b1; MEM_AluResult = 32'h8;
    @(posedge clk); #1;
    chk("mid_req", 32'(dmem_req), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_req", 32'(dmem_req), 0);
    chk_wb(0, 0, 0, 0, 0, 0, 0);
    last_rd = '0;
    MEM_MemToReg = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    run_op(1, 0, 0, 9, 32'hCAFE, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
